// File: rtl/load_store_unit_if.sv
// Bundle of upstream handshake, memory bus and writeback signals for the load/store unit.
// Signal suffixes are from the unit's point of view; "slave" is the unit, "master" its environment.
interface load_store_unit_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] inst_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  logic        wb_valid_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_err_o;

  modport slave (
    input  valid_i, inst_i, addr_i, wdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, wb_err_o
  );

  modport master (
    output valid_i, inst_i, addr_i, wdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, wb_err_o
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store stage: issues aligned memory accesses, extracts load data and flags
// misalignment, illegal funct3 and bus timeouts; other instructions pass their ALU result through.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave lsu
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam logic [15:0] CntMax = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic        st_q, st_d;
  logic [4:0]  rd_q, rd_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic        wb_we_q, wb_we_d;
  logic        wb_err_q, wb_err_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        is_load, is_store, is_mem, legal_f3, misalign, mem_ok;
  logic [3:0]  lane_strb;
  logic [31:0] lane_data, rshift, load_val;
  logic        unused_inst;

  assign opcode      = lsu.inst_i[6:0];
  assign rd          = lsu.inst_i[11:7];
  assign funct3      = lsu.inst_i[14:12];
  assign unused_inst = ^lsu.inst_i[31:15];

  assign is_load  = (opcode == 7'b0000011);
  assign is_store = (opcode == 7'b0100011);
  assign is_mem   = is_load | is_store;
  assign legal_f3 = is_load ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                            : (funct3 inside {3'b000, 3'b001, 3'b010});
  // funct3[1:0] encodes access size for every legal load/store
  assign misalign = ((funct3[1:0] == 2'b01) && lsu.addr_i[0]) ||
                    ((funct3[1:0] == 2'b10) && (lsu.addr_i[1:0] != 2'b00));
  assign mem_ok   = is_mem && legal_f3 && !misalign;

  always_comb begin
    lane_strb = 4'b1111;
    lane_data = lsu.wdata_i;
    case (funct3[1:0])
      2'b00: begin
        lane_strb = 4'b0001 << lsu.addr_i[1:0];
        lane_data = {4{lsu.wdata_i[7:0]}};
      end
      2'b01: begin
        lane_strb = 4'b0011 << {lsu.addr_i[1], 1'b0};
        lane_data = {2{lsu.wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign rshift = lsu.mem_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_val = rshift;
    case (f3_q)
      3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_val = {24'h0, rshift[7:0]};
      3'b101:  load_val = {16'h0, rshift[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    f3_d      = f3_q;
    st_d      = st_q;
    rd_d      = rd_q;
    wstrb_d   = wstrb_q;
    mwdata_d  = mwdata_q;
    wb_we_d   = wb_we_q;
    wb_err_d  = wb_err_q;
    wb_data_d = wb_data_q;
    unique case (state_q)
      StIdle: begin
        if (lsu.valid_i) begin
          addr_d   = lsu.addr_i;
          f3_d     = funct3;
          st_d     = is_store;
          rd_d     = rd;
          cnt_d    = '0;
          wstrb_d  = is_store ? lane_strb : 4'b0000;
          mwdata_d = lane_data;
          if (mem_ok) begin
            state_d = StReq;
          end else begin
            // Non-memory pass-through, or a faulting load/store that never reaches the bus
            state_d   = StDone;
            wb_err_d  = is_mem;
            wb_we_d   = !is_mem && (rd != 5'd0);
            wb_data_d = lsu.addr_i;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == CntMax) begin
          state_d   = StDone;
          wb_err_d  = 1'b1;
          wb_we_d   = 1'b0;
          wb_data_d = addr_q;
        end else if (lsu.mem_gnt_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 16'd1;
        // A response arriving in the last allowed cycle still completes the access
        if (lsu.mem_rvalid_i) begin
          state_d   = StDone;
          wb_err_d  = 1'b0;
          wb_we_d   = !st_q && (rd_q != 5'd0);
          wb_data_d = st_q ? 32'h0 : load_val;
        end else if (cnt_q == CntMax) begin
          state_d   = StDone;
          wb_err_d  = 1'b1;
          wb_we_d   = 1'b0;
          wb_data_d = addr_q;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      f3_q      <= '0;
      st_q      <= 1'b0;
      rd_q      <= '0;
      wstrb_q   <= '0;
      mwdata_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_err_q  <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      f3_q      <= f3_d;
      st_q      <= st_d;
      rd_q      <= rd_d;
      wstrb_q   <= wstrb_d;
      mwdata_q  <= mwdata_d;
      wb_we_q   <= wb_we_d;
      wb_err_q  <= wb_err_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Bus and writeback outputs are qualified by state so they read zero whenever idle
  logic in_req, in_done;
  assign in_req  = (state_q == StReq);
  assign in_done = (state_q == StDone);

  assign lsu.ready_o     = (state_q == StIdle);
  assign lsu.mem_req_o   = in_req;
  assign lsu.mem_we_o    = in_req & st_q;
  assign lsu.mem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign lsu.mem_wdata_o = in_req ? mwdata_q : 32'h0;
  assign lsu.mem_wstrb_o = in_req ? wstrb_q : 4'b0000;

  assign lsu.wb_valid_o  = in_done;
  assign lsu.wb_we_o     = in_done & wb_we_q;
  assign lsu.wb_err_o    = in_done & wb_err_q;
  assign lsu.wb_rd_o     = in_done ? rd_q : 5'd0;
  assign lsu.wb_data_o   = in_done ? wb_data_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes model predictions, a negedge monitor
// pops and compares memory requests and writeback pulses.
module tb_load_store_unit;
  localparam int T = 4;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpAdd   = 7'b0110011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  load_store_unit #(.TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .lsu(bus));

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          chk_wdata;
    int          len;
  } mem_t;

  wb_t  wb_q[$];
  mem_t mem_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: access size from funct3, alignment by modulo, lane data by byte arithmetic.
  function automatic void model(input logic [31:0] inst, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rdata,
                                input int g, input int r,
                                output bit is_mem, output wb_t w, output mem_t m);
    int          size;
    bit          ld, st, bad;
    logic [31:0] val;
    ld = (inst[6:0] == OpLoad);
    st = (inst[6:0] == OpStore);
    size = 0;
    if (ld) begin
      case (inst[14:12])
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        3'd2:       size = 4;
        default:    size = 0;
      endcase
    end
    if (st) begin
      case (inst[14:12])
        3'd0:    size = 1;
        3'd1:    size = 2;
        3'd2:    size = 4;
        default: size = 0;
      endcase
    end
    bad = (ld || st) && ((size == 0) ? 1'b1 : ((addr % size) != 0));
    is_mem = 0;
    m = '{default: 0};
    w.rd = inst[11:7];
    w.err = 0;
    w.we = 0;
    w.data = addr;
    w.cyc = 1;
    if (bad) begin
      w.err = 1;
    end else if (!ld && !st) begin
      w.we = (w.rd != 0);
    end else begin
      is_mem = 1;
      m.addr = addr & 32'hFFFF_FFFC;
      m.we = st;
      m.wstrb = st ? 4'(((1 << size) - 1) << addr[1:0]) : 4'b0000;
      for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      m.chk_wdata = st;
      m.len = (g + 1 < T) ? g + 1 : T;
      if (g + r + 2 > T) begin
        w.err = 1;
        w.cyc = T + 1;
      end else begin
        w.cyc = g + r + 3;
        if (st) begin
          w.data = 0;
        end else begin
          val = rdata >> (8 * addr[1:0]);
          if (size == 1) val = val & 32'hFF;
          if (size == 2) val = val & 32'hFFFF;
          if (size == 1 && !inst[14] && val >= 128) val = val - 32'd256;
          if (size == 2 && !inst[14] && val >= 32768) val = val - 32'd65536;
          w.data = val;
          w.we = (w.rd != 0);
        end
      end
    end
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [4:0] rd);
    logic [31:0] x;
    x = $urandom;
    x[6:0] = op;
    x[11:7] = rd;
    x[14:12] = f3;
    return x;
  endfunction

  task automatic wait_ready();
    int t;
    t = 0;
    while (!bus.ready_o && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("ready_before_issue", bus.ready_o, 1'b1);
  endtask

  // Issue one instruction and act as the memory: grant after g cycles, respond r cycles later.
  task automatic issue(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdata, input int g, input int r, input bit stray);
    bit   is_mem;
    wb_t  w;
    mem_t m;
    model(inst, addr, wd, rdata, g, r, is_mem, w, m);
    wait_ready();
    bus.valid_i = 1'b1;
    bus.inst_i  = inst;
    bus.addr_i  = addr;
    bus.wdata_i = wd;
    if (is_mem) mem_q.push_back(m);
    w.cyc = w.cyc + cyc;
    wb_q.push_back(w);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.inst_i  = $urandom;
    bus.addr_i  = $urandom;
    bus.wdata_i = $urandom;
    if (is_mem) begin
      for (int k = 0; k < g; k++) begin
        bus.mem_rvalid_i = stray && (k == 1);
        bus.mem_rdata_i  = $urandom;
        @(posedge clk);
        #1;
      end
      bus.mem_rvalid_i = 1'b0;
      bus.mem_gnt_i = 1'b1;
      @(posedge clk);
      #1;
      bus.mem_gnt_i = 1'b0;
      repeat (r) begin
        bus.mem_rdata_i = $urandom;
        @(posedge clk);
        #1;
      end
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = rdata;
      @(posedge clk);
      #1;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = $urandom;
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", bus.ready_o, 1'b1);
    chk("rst_mem_req", bus.mem_req_o, 1'b0);
    chk("rst_mem_we", bus.mem_we_o, 1'b0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
    chk("rst_mem_wstrb", bus.mem_wstrb_o, 4'h0);
    chk("rst_wb_valid", bus.wb_valid_o, 1'b0);
    chk("rst_wb_we", bus.wb_we_o, 1'b0);
    chk("rst_wb_err", bus.wb_err_o, 1'b0);
    chk("rst_wb_rd", bus.wb_rd_o, 5'd0);
    chk("rst_wb_data", bus.wb_data_o, 32'h0);
  endtask

  // Monitor: memory request fields/length and writeback pulses against queued predictions.
  int  req_len = 0;
  bit  prev_req = 0;
  wb_t mon_w;
  always @(negedge clk) begin
    if (!rst_n) begin
      req_len = 0;
      prev_req = 0;
    end else begin
      if (bus.mem_req_o) begin
        if (mem_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL mem_req_unexpected: actual=1 required=0 (t=%0t)", $time);
        end else begin
          chk("mem_addr", bus.mem_addr_o, mem_q[0].addr);
          chk("mem_we", bus.mem_we_o, mem_q[0].we);
          chk("mem_wstrb", bus.mem_wstrb_o, mem_q[0].wstrb);
          if (mem_q[0].chk_wdata) chk("mem_wdata", bus.mem_wdata_o, mem_q[0].wdata);
        end
        req_len++;
      end else if (prev_req) begin
        if (mem_q.size() != 0) begin
          chk("mem_req_len", req_len, mem_q[0].len);
          void'(mem_q.pop_front());
        end
        req_len = 0;
      end
      prev_req = bus.mem_req_o;
      if (bus.wb_valid_o) begin
        if (wb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL wb_valid_unexpected: actual=1 required=0 (t=%0t)", $time);
        end else begin
          mon_w = wb_q.pop_front();
          chk("wb_cycle", cyc, mon_w.cyc);
          chk("wb_we", bus.wb_we_o, mon_w.we);
          chk("wb_rd", bus.wb_rd_o, mon_w.rd);
          chk("wb_data", bus.wb_data_o, mon_w.data);
          chk("wb_err", bus.wb_err_o, mon_w.err);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          m_mem;
    wb_t         m_w;
    mem_t        m_m;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    int          g, r, kind;

    bus.valid_i = 0; bus.inst_i = 0; bus.addr_i = 0; bus.wdata_i = 0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(mk(OpLoad, 3'b000, 5'd1), 32'h1003, $urandom, 32'h80FF_1234, 0, 0, 0);
    issue(mk(OpStore, 3'b001, 5'd7), 32'h2002, 32'h0000_ABCD, $urandom, 0, 0, 0);
    issue(mk(OpLoad, 3'b010, 5'd3), 32'h3001, $urandom, $urandom, 0, 0, 0);
    issue(mk(OpAdd, 3'b000, 5'd5), 32'h1234, $urandom, $urandom, 0, 0, 0);
    chk("busy_after_passthru", bus.ready_o, 1'b0);
    @(posedge clk);
    #1;
    chk("ready_two_cycles_after_accept", bus.ready_o, 1'b1);
    issue(mk(OpAdd, 3'b000, 5'd0), 32'h1234, $urandom, $urandom, 0, 0, 0);
    issue(mk(OpLoad, 3'b010, 5'd9), 32'h5000, $urandom, $urandom, 10, 0, 1);
    issue(mk(OpLoad, 3'b101, 5'd4), 32'h0000_0102, $urandom, 32'h9876_5432, 1, 0, 0);
    issue(mk(OpLoad, 3'b100, 5'd6), 32'h0000_0201, $urandom, 32'hCAFE_F00D, 0, 1, 0);
    issue(mk(OpStore, 3'b000, 5'd2), 32'h0000_0403, 32'h1234_5678, $urandom, 0, 0, 0);
    issue(mk(OpStore, 3'b010, 5'd8), 32'h0000_0800, 32'hDEAD_BEEF, $urandom, 1, 1, 0);
    issue(mk(OpLoad, 3'b011, 5'd10), 32'h0000_0000, $urandom, $urandom, 0, 0, 0);
    issue(mk(OpStore, 3'b100, 5'd11), 32'h0000_0000, $urandom, $urandom, 0, 0, 0);

    // Reset while an access waits for its response
    wait_ready();
    model(mk(OpLoad, 3'b010, 5'd12), 32'h4000, 0, 0, 0, 0, m_mem, m_w, m_m);
    mem_q.push_back(m_m);
    bus.valid_i = 1'b1;
    bus.inst_i  = mk(OpLoad, 3'b010, 5'd12);
    bus.addr_i  = 32'h4000;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.mem_gnt_i = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_gnt_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    wb_q.delete();
    mem_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i = 32'h1111_2222;
    repeat (5) begin
      @(posedge clk);
      #1;
      bus.mem_rvalid_i = 1'b0;
      chk("no_wb_after_reset", bus.wb_valid_o, 1'b0);
      chk("no_req_after_reset", bus.mem_req_o, 1'b0);
    end

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      if (kind < 4) begin
        op = OpLoad;
        f3 = 3'($urandom_range(0, 5));
        if (f3 == 3'd3) f3 = 3'd4;
      end else if (kind < 7) begin
        op = OpStore;
        f3 = 3'($urandom_range(0, 2));
      end else begin
        op = 7'($urandom);
        if (op == OpLoad || op == OpStore) op = OpAdd;
        f3 = 3'($urandom);
      end
      if ($urandom_range(0, 15) == 0) f3 = 3'($urandom);
      g = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      r = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      issue(mk(op, f3, 5'($urandom)), a, $urandom, $urandom, g, r, 1'($urandom_range(0, 1)));
    end

    repeat (8) @(posedge clk);
    #1;
    chk("wb_queue_drained", wb_q.size(), 0);
    chk("mem_queue_drained", mem_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
